// File: rtl/mux5_pkg.sv
// mux5_pkg
// Purpose : shared select encoding for the 5-channel multiplexer.
// Contents: sel_t (3-bit select type), SEL_A..SEL_E channel codes, SEL_MAX
//           (highest legal code), sel_is_legal() helper.
package mux5_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_A   = 3'd0;
    localparam sel_t SEL_B   = 3'd1;
    localparam sel_t SEL_C   = 3'd2;
    localparam sel_t SEL_D   = 3'd3;
    localparam sel_t SEL_E   = 3'd4;
    localparam sel_t SEL_MAX = SEL_E;

    function automatic logic sel_is_legal(input sel_t sel);
        return (sel <= SEL_MAX);
    endfunction

endpackage

// File: rtl/multiplexer_5ch_if.sv
// multiplexer_5ch_if
// Purpose : bundles the request side (five data channels, select, valid) and
//           the registered response side of the 5-channel multiplexer.
// Ports   : data_a..data_e, sel, in_valid  - request, driven by the master
//           mux_out, out_valid, sel_err    - response, driven by the slave
// Modports: master (requester), slave (multiplexer_5ch).
interface multiplexer_5ch_if
    import mux5_pkg::*;
#(
    parameter int unsigned word_size = 8
);
    logic [word_size-1:0] data_a;
    logic [word_size-1:0] data_b;
    logic [word_size-1:0] data_c;
    logic [word_size-1:0] data_d;
    logic [word_size-1:0] data_e;
    sel_t                 sel;
    logic                 in_valid;
    logic [word_size-1:0] mux_out;
    logic                 out_valid;
    logic                 sel_err;

    modport master (
        output data_a, data_b, data_c, data_d, data_e, sel, in_valid,
        input  mux_out, out_valid, sel_err
    );

    modport slave (
        input  data_a, data_b, data_c, data_d, data_e, sel, in_valid,
        output mux_out, out_valid, sel_err
    );

endinterface

// File: rtl/mux5_select.sv
// mux5_select
// Purpose : purely combinational 5:1 word select with illegal-select detect.
// Ports   : i_data_a..i_data_e - channel words (opaque bit vectors)
//           i_sel              - channel select, legal 0..4
//           o_data             - selected word, all zeros for an illegal select
//           o_sel_err          - high when i_sel is 5..7
module mux5_select
    import mux5_pkg::*;
#(
    parameter int unsigned word_size = 8
) (
    input  logic [word_size-1:0] i_data_a,
    input  logic [word_size-1:0] i_data_b,
    input  logic [word_size-1:0] i_data_c,
    input  logic [word_size-1:0] i_data_d,
    input  logic [word_size-1:0] i_data_e,
    input  sel_t                 i_sel,
    output logic [word_size-1:0] o_data,
    output logic                 o_sel_err
);

    always_comb begin
        o_data    = '0;
        o_sel_err = !sel_is_legal(i_sel);
        // Only the addressed channel reaches o_data, so unknowns on the
        // other channels cannot propagate.
        case (i_sel)
            SEL_A:   o_data = i_data_a;
            SEL_B:   o_data = i_data_b;
            SEL_C:   o_data = i_data_c;
            SEL_D:   o_data = i_data_d;
            SEL_E:   o_data = i_data_e;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/multiplexer_5ch.sv
// multiplexer_5ch
// Purpose : registered 5-channel multiplexer. A request (in_valid=1) captures
//           the selected channel on the rising edge; the result is presented
//           one clock later with out_valid. Without a request the result and
//           error flag hold and out_valid drops.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset, clears all outputs
//           bus   - multiplexer_5ch_if slave modport (request in, result out)
module multiplexer_5ch
    import mux5_pkg::*;
#(
    parameter int unsigned word_size = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multiplexer_5ch_if.slave         bus
);

    logic [word_size-1:0] w_sel_data;
    logic                 w_sel_err;

    logic [word_size-1:0] r_mux_out;
    logic                 r_out_valid;
    logic                 r_sel_err;

    mux5_select #(
        .word_size (word_size)
    ) u_select (
        .i_data_a  (bus.data_a),
        .i_data_b  (bus.data_b),
        .i_data_c  (bus.data_c),
        .i_data_d  (bus.data_d),
        .i_data_e  (bus.data_e),
        .i_sel     (bus.sel),
        .o_data    (w_sel_data),
        .o_sel_err (w_sel_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mux_out   <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_mux_out <= w_sel_data;
                r_sel_err <= w_sel_err;
            end
        end
    end

    assign bus.mux_out   = r_mux_out;
    assign bus.out_valid = r_out_valid;
    assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_multiplexer_5ch.sv
// tb_multiplexer_5ch
// Purpose : directed scoreboard bench for multiplexer_5ch. Requests push the
//           hand-computed result into a queue; per-DUT monitors pop and compare
//           whenever out_valid is seen, and check out_valid against the
//           request seen at each edge. An 8-bit and a 16-bit instance are used.
module tb_multiplexer_5ch;
    import mux5_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    multiplexer_5ch_if #(.word_size(8))  b8 ();
    multiplexer_5ch_if #(.word_size(16)) b16 ();

    multiplexer_5ch #(.word_size(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    multiplexer_5ch #(.word_size(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Issue one request on the 8-bit DUT at the next negedge.
    task automatic req8(input logic v, input sel_t s, input logic [7:0] exp,
                        input logic experr);
        exp_t e;
        @(negedge clk);
        b8.in_valid = v;
        b8.sel      = s;
        if (v && rst_n) begin
            e.data = {8'h00, exp};
            e.err  = experr;
            q8.push_back(e);
        end
    endtask

    task automatic req16(input logic v, input sel_t s, input logic [15:0] exp,
                         input logic experr);
        exp_t e;
        @(negedge clk);
        b16.in_valid = v;
        b16.sel      = s;
        if (v && rst_n) begin
            e.data = exp;
            e.err  = experr;
            q16.push_back(e);
        end
    endtask

    // Monitor, 8-bit DUT.
    initial begin
        logic lv;
        exp_t e;
        forever begin
            @(posedge clk);
            lv = b8.in_valid & rst_n;
            #1;
            check("out_valid8", {15'h0, b8.out_valid}, {15'h0, lv & rst_n});
            if (b8.out_valid) begin
                if (q8.size() == 0) begin
                    check("unexpected_out8", {15'h0, b8.out_valid}, 16'h0);
                end else begin
                    e = q8.pop_front();
                    check("mux_out8", {8'h00, b8.mux_out}, e.data);
                    check("sel_err8", {15'h0, b8.sel_err}, {15'h0, e.err});
                end
            end
        end
    end

    // Monitor, 16-bit DUT.
    initial begin
        logic lv;
        exp_t e;
        forever begin
            @(posedge clk);
            lv = b16.in_valid & rst_n;
            #1;
            check("out_valid16", {15'h0, b16.out_valid}, {15'h0, lv & rst_n});
            if (b16.out_valid) begin
                if (q16.size() == 0) begin
                    check("unexpected_out16", {15'h0, b16.out_valid}, 16'h0);
                end else begin
                    e = q16.pop_front();
                    check("mux_out16", b16.mux_out, e.data);
                    check("sel_err16", {15'h0, b16.sel_err}, {15'h0, e.err});
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b8.in_valid  = 1'b0;
        b8.sel       = SEL_A;
        b8.data_a    = 8'hFC;
        b8.data_b    = 8'hFD;
        b8.data_c    = 8'hFE;
        b8.data_d    = 8'hFF;
        b8.data_e    = 8'hFB;
        b16.in_valid = 1'b0;
        b16.sel      = SEL_A;
        b16.data_a   = 16'h1234;
        b16.data_b   = 16'h5678;
        b16.data_c   = 16'h9ABC;
        b16.data_d   = 16'hDEF0;
        b16.data_e   = 16'hA5A5;

        // Power-on reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_mux_out8", {8'h00, b8.mux_out}, 16'h0000);
        check("rst_sel_err8", {15'h0, b8.sel_err}, 16'h0000);
        check("rst_mux_out16", b16.mux_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep of legal selects, back to back.
        req8(1'b1, SEL_A, 8'hFC, 1'b0);
        req8(1'b1, SEL_B, 8'hFD, 1'b0);
        req8(1'b1, SEL_C, 8'hFE, 1'b0);
        req8(1'b1, SEL_D, 8'hFF, 1'b0);
        req8(1'b1, SEL_E, 8'hFB, 1'b0);

        // Illegal selects, then recovery.
        req8(1'b1, 3'd5, 8'h00, 1'b1);
        req8(1'b1, 3'd6, 8'h00, 1'b1);
        req8(1'b1, 3'd7, 8'h00, 1'b1);
        req8(1'b1, SEL_C, 8'hFE, 1'b0);

        // Error flag holds while idle.
        req8(1'b1, 3'd6, 8'h00, 1'b1);
        req8(1'b0, SEL_A, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("hold_sel_err", {15'h0, b8.sel_err}, 16'h0001);
        check("hold_zero", {8'h00, b8.mux_out}, 16'h0000);

        // Data hold while idle, with select and data changing.
        req8(1'b1, SEL_D, 8'hFF, 1'b0);
        @(negedge clk);
        b8.in_valid = 1'b0;
        b8.sel      = SEL_A;
        b8.data_a   = 8'h11;
        b8.data_d   = 8'h22;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold_mux_out", {8'h00, b8.mux_out}, 16'h00FF);
            check("hold_out_valid", {15'h0, b8.out_valid}, 16'h0000);
        end

        // Isolation: unselected channels unknown.
        @(negedge clk);
        b8.data_a = 'x;
        b8.data_c = 'x;
        b8.data_d = 'x;
        b8.data_e = 'x;
        req8(1'b1, SEL_B, 8'hFD, 1'b0);
        req8(1'b0, SEL_B, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("iso_unknown", {15'h0, $isunknown({b8.mux_out, b8.out_valid, b8.sel_err})},
              16'h0000);
        check("iso_mux_out", {8'h00, b8.mux_out}, 16'h00FD);

        // Restore data, capture FF, then asynchronous reset mid-cycle.
        @(negedge clk);
        b8.data_a = 8'hFC;
        b8.data_c = 8'hFE;
        b8.data_d = 8'hFF;
        b8.data_e = 8'hFB;
        req8(1'b1, SEL_D, 8'hFF, 1'b0);
        @(negedge clk);
        b8.in_valid = 1'b1;   // pending request, discarded by reset
        b8.sel      = SEL_A;
        #1;
        check("pre_rst_mux_out", {8'h00, b8.mux_out}, 16'h00FF);
        rst_n = 1'b0;
        #1;
        check("async_rst_mux_out", {8'h00, b8.mux_out}, 16'h0000);
        check("async_rst_out_valid", {15'h0, b8.out_valid}, 16'h0000);
        check("async_rst_sel_err", {15'h0, b8.sel_err}, 16'h0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("in_rst_mux_out", {8'h00, b8.mux_out}, 16'h0000);
        end
        @(negedge clk);
        b8.in_valid = 1'b0;
        rst_n = 1'b1;
        req8(1'b1, SEL_E, 8'hFB, 1'b0);
        req8(1'b0, SEL_A, 8'h00, 1'b0);

        // 16-bit instance.
        req16(1'b1, SEL_E, 16'hA5A5, 1'b0);
        req16(1'b1, SEL_A, 16'h1234, 1'b0);
        req16(1'b1, 3'd7, 16'h0000, 1'b1);
        req16(1'b1, SEL_D, 16'hDEF0, 1'b0);
        req16(1'b0, SEL_A, 16'h0000, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("q8_drained", 16'(q8.size()), 16'h0000);
        check("q16_drained", 16'(q16.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplexer_5ch.md
MULTIPLEXER_5CH -- requirements
Module: multiplexer_5ch

Interface
REQ-001 Parameter: word_size, default 8, data path width in bits of every data input and of mux_out.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_a  input  word_size  channel 0 data.
REQ-005 data_b  input  word_size  channel 1 data.
REQ-006 data_c  input  word_size  channel 2 data.
REQ-007 data_d  input  word_size  channel 3 data.
REQ-008 data_e  input  word_size  channel 4 data.
REQ-009 sel  input  3  channel select; legal values 0..4.
REQ-010 in_valid  input  1  sample request; sel and data are captured only when high.
REQ-011 mux_out  output  word_size  registered selected data.
REQ-012 out_valid  output  1  high for exactly the cycle(s) following a captured request.
REQ-013 sel_err  output  1  registered flag, high when the captured sel was illegal (5..7).

Function
REQ-014 Select map SHALL be: sel 0 -> data_a, 1 -> data_b, 2 -> data_c, 3 -> data_d, 4 -> data_e.
REQ-015 Latency SHALL be one clock: values present at rising edge N with in_valid=1 appear on mux_out at edge N (visible after N, through N+1).
REQ-016 out_valid SHALL equal in_valid delayed by one clock; back-to-back requests give continuous out_valid.
REQ-017 When in_valid=0 at an edge, mux_out and sel_err SHALL hold their previous values and out_valid SHALL go 0.
REQ-018 Illegal sel (5, 6, 7) with in_valid=1 SHALL load mux_out with all zeros and set sel_err=1.
REQ-019 Legal sel with in_valid=1 SHALL clear sel_err to 0.
REQ-020 Data inputs SHALL be treated as opaque bit vectors; no arithmetic, no width extension or truncation.
REQ-021 No combinational path from any input to any output.
REQ-022 X/Z on a data input not selected SHALL NOT affect mux_out.

Reset
REQ-023 rst_n=0 SHALL immediately (without clock) force mux_out=0, out_valid=0, sel_err=0.
REQ-024 Outputs SHALL stay at reset values while rst_n=0 regardless of clk, in_valid, sel.
REQ-025 Reset asserted mid-operation SHALL discard any request captured in the same cycle; first capture is the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-026 Shared package mux5_pkg SHALL hold select constants SEL_A=0 .. SEL_E=4, SEL_MAX=4 and the 3-bit select type.
REQ-027 One sub-module mux5_select (pure combinational 5:1 select plus illegal-select detect) SHALL be instantiated by the registered top.
REQ-028 All flops SHALL reside in multiplexer_5ch; reset style uniform across all of them.

Verification
REQ-029 Reset: rst_n=0 mid-cycle with mux_out=FF -> mux_out=00, out_valid=0, sel_err=0 immediately.
REQ-030 Sweep (word_size=8): a=FC, b=FD, c=FE, d=FF, e=FB, in_valid=1, sel 0..4 on successive edges -> mux_out FC, FD, FE, FF, FB one cycle later each, out_valid=1, sel_err=0.
REQ-031 Illegal: sel=5, 6, 7 with same data -> mux_out=00, sel_err=1; next sel=2 -> mux_out=FE, sel_err=0.
REQ-032 Hold: capture sel=3 (FF), then in_valid=0 while sel and data change -> mux_out stays FF, out_valid=0.
REQ-033 Isolation: sel=1, data_a/c/d/e driven X -> mux_out=FD, no X on any output.
REQ-034 Parameter: word_size=16, data_e=A5A5, sel=4 -> mux_out=A5A5 after one clock.
